alu: RTL and testbench

// - Registered 32-bit integer ALU for the MIPS-style pipeline execute stage.
// - Decoder supplies instruction class, opcode/funct, two register operands and a 16-bit immediate.
// - Produces a signed 32-bit result and a branch-taken flag, both one clock after the inputs.

---
 rtl/alu.sv | 78 +++++++
 tb/tb_alu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: registered 32-bit execute-stage ALU producing a result and a branch-taken flag one cycle after its inputs
module alu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  type_inst,
  input  logic [5:0]  opcode,
  input  logic [31:0] Rs1_val,
  input  logic [31:0] Rs2_val,
  input  logic [15:0] imm,
  output logic        condition,
  output logic [31:0] res
);
  logic [31:0] a, b, se, ze, off, r;
  logic [4:0]  sh;
  logic        c, bv;
  assign a   = Rs1_val;
  assign b   = Rs2_val;
  assign sh  = b[4:0];
  assign se  = {{16{imm[15]}}, imm};
  assign ze  = {16'b0, imm};
  assign off = {se[29:0], 2'b00};
  assign bv  = opcode inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
  always_comb begin
    r = '0;
    c = 1'b0;
    case (type_inst)
      2'b01:
        case (opcode)
          6'h20, 6'h21: r = a + b;
          6'h22, 6'h23: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h26: r = a ^ b;
          6'h27: r = ~(a | b);
          6'h2a: r = {31'b0, $signed(a) < $signed(b)};
          6'h2b: r = {31'b0, a < b};
          6'h00, 6'h04: r = a << sh;
          6'h02, 6'h06: r = a >> sh;
          6'h03, 6'h07: r = $signed(a) >>> sh;
          default: r = '0;
        endcase
      2'b00:
        case (opcode)
          6'h08, 6'h09, 6'h23, 6'h2b: r = a + se;
          6'h0a: r = {31'b0, $signed(a) < $signed(se)};
          6'h0b: r = {31'b0, a < se};
          6'h0c: r = a & ze;
          6'h0d: r = a | ze;
          6'h0e: r = a ^ ze;
          6'h0f: r = {imm, 16'b0};
          default: r = '0;
        endcase
      2'b10: begin
        r = bv ? off : '0;
        case (opcode)
          6'h04: c = a == b;
          6'h05: c = a != b;
          6'h06: c = $signed(a) <= 0;
          6'h07: c = $signed(a) > 0;
          6'h01: c = $signed(a) < 0;
          default: c = 1'b0;
        endcase
      end
      default: begin
        r = off;
        c = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      res       <= '0;
      condition <= 1'b0;
    end else begin
      res       <= r;
      condition <= c;
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table, reset corner sequences and randomized checks against an arithmetic reference model
module tb_alu;
  logic        clk = 0, reset_n = 0;
  logic [1:0]  type_inst = 0;
  logic [5:0]  opcode = 0;
  logic [31:0] Rs1_val = 0, Rs2_val = 0;
  logic [15:0] imm = 0;
  logic        condition;
  logic [31:0] res;
  int checks = 0, errors = 0;

  alu dut (.clk(clk), .reset_n(reset_n), .type_inst(type_inst), .opcode(opcode),
           .Rs1_val(Rs1_val), .Rs2_val(Rs2_val), .imm(imm), .condition(condition), .res(res));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [5:0]  op;
    logic [31:0] a, b;
    logic [15:0] imm;
    logic [31:0] r;
    logic        c;
  } vec_t;

  function automatic logic [32:0] model(logic [1:0] t, logic [5:0] op, logic [31:0] a, logic [31:0] b, logic [15:0] im);
    longint sa, sb, ua, ub, si, ui, p, v;
    logic c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    si = longint'($signed(im));
    ui = longint'({16'b0, im});
    p  = longint'(1) << b[4:0];
    v  = 0;
    c  = 0;
    if (t == 2'b01) begin
      if (op == 6'h20 || op == 6'h21) v = sa + sb;
      else if (op == 6'h22 || op == 6'h23) v = sa - sb;
      else if (op == 6'h24) v = ua & ub;
      else if (op == 6'h25) v = ua | ub;
      else if (op == 6'h26) v = ua ^ ub;
      else if (op == 6'h27) v = 64'hFFFFFFFF - (ua | ub);
      else if (op == 6'h2a) v = (sa < sb) ? 1 : 0;
      else if (op == 6'h2b) v = (ua < ub) ? 1 : 0;
      else if (op == 6'h00 || op == 6'h04) v = ua * p;
      else if (op == 6'h02 || op == 6'h06) v = ua / p;
      else if (op == 6'h03 || op == 6'h07) v = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
    end else if (t == 2'b00) begin
      if (op == 6'h08 || op == 6'h09 || op == 6'h23 || op == 6'h2b) v = sa + si;
      else if (op == 6'h0a) v = (sa < si) ? 1 : 0;
      else if (op == 6'h0b) v = (ua < (si & 64'hFFFFFFFF)) ? 1 : 0;
      else if (op == 6'h0c) v = ua & ui;
      else if (op == 6'h0d) v = ua | ui;
      else if (op == 6'h0e) v = ua ^ ui;
      else if (op == 6'h0f) v = ui * 65536;
    end else if (t == 2'b10) begin
      if (op == 6'h04 || op == 6'h05 || op == 6'h06 || op == 6'h07 || op == 6'h01) v = si * 4;
      if (op == 6'h04) c = (sa == sb);
      else if (op == 6'h05) c = (sa != sb);
      else if (op == 6'h06) c = (sa <= 0);
      else if (op == 6'h07) c = (sa > 0);
      else if (op == 6'h01) c = (sa < 0);
    end else begin
      v = si * 4;
      c = 1;
    end
    return {c, v[31:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] er, input logic ec);
    checks++;
    if (res !== er || condition !== ec) begin
      errors++;
      $display("FAIL %s: got res=%h cond=%b, expected res=%h cond=%b", name, res, condition, er, ec);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
    type_inst = t; opcode = op; Rs1_val = a; Rs2_val = b; imm = im;
  endtask

  vec_t vt[$];
  logic [32:0] m;

  initial begin
    vt.push_back('{2'b01, 6'h20, 32'd3, 32'd4, 16'h0, 32'd7, 1'b0});
    vt.push_back('{2'b01, 6'h20, 32'd3, -32'sd4, 16'h0, 32'hFFFFFFFF, 1'b0});
    vt.push_back('{2'b01, 6'h2a, 32'd3, 32'd4, 16'h0, 32'd1, 1'b0});
    vt.push_back('{2'b01, 6'h2a, 32'd4, 32'd3, 16'h0, 32'd0, 1'b0});
    vt.push_back('{2'b01, 6'h2b, 32'hFFFFFFFF, 32'd1, 16'h0, 32'd0, 1'b0});
    vt.push_back('{2'b01, 6'h2a, 32'hFFFFFFFF, 32'd1, 16'h0, 32'd1, 1'b0});
    vt.push_back('{2'b00, 6'h08, 32'd10, 32'd0, 16'hFFFF, 32'd9, 1'b0});
    vt.push_back('{2'b00, 6'h0c, 32'hFFFFFFFF, 32'd0, 16'h8001, 32'h00008001, 1'b0});
    vt.push_back('{2'b00, 6'h0f, 32'd0, 32'd0, 16'h1234, 32'h12340000, 1'b0});
    vt.push_back('{2'b10, 6'h04, 32'd5, 32'd5, 16'd3, 32'd12, 1'b1});
    vt.push_back('{2'b10, 6'h05, 32'd5, 32'd5, 16'd3, 32'd12, 1'b0});
    vt.push_back('{2'b10, 6'h07, 32'd0, 32'd5, 16'd3, 32'd12, 1'b0});
    vt.push_back('{2'b01, 6'h20, 32'h7FFFFFFF, 32'd1, 16'h0, 32'h80000000, 1'b0});
    vt.push_back('{2'b01, 6'h03, -32'sd8, 32'd1, 16'h0, 32'hFFFFFFFC, 1'b0});
    vt.push_back('{2'b11, 6'h02, 32'd0, 32'd0, 16'hFFFE, 32'hFFFFFFF8, 1'b1});
    vt.push_back('{2'b01, 6'h3f, 32'd1, 32'd2, 16'h0, 32'd0, 1'b0});
    vt.push_back('{2'b10, 6'h02, 32'd1, 32'd1, 16'd7, 32'd0, 1'b0});

    drive(2'b11, 6'h00, 32'd1, 32'd1, 16'h7FFF);
    #1 chk("reset_async", 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", 32'd0, 1'b0);
    reset_n = 1;

    foreach (vt[i]) begin
      drive(vt[i].t, vt[i].op, vt[i].a, vt[i].b, vt[i].imm);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), vt[i].r, vt[i].c);
    end

    drive(2'b11, 6'h00, 32'd0, 32'd0, 16'h0010);
    @(posedge clk); #1;
    chk("pre_reset_jump", 32'h40, 1'b1);
    drive(2'b01, 6'h20, 32'd100, 32'd23, 16'h0);
    #2 reset_n = 0;
    #1 chk("mid_reset_async", 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("mid_reset_discard", 32'd0, 1'b0);
    @(negedge clk) reset_n = 1;
    drive(2'b01, 6'h22, 32'd100, 32'd23, 16'h0);
    @(posedge clk); #1;
    chk("post_reset_first", 32'd77, 1'b0);

    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom,
            ($urandom_range(0, 3) == 0) ? Rs1_val : $urandom, 16'($urandom));
      m = model(type_inst, opcode, Rs1_val, Rs2_val, imm);
      @(posedge clk); #1;
      chk($sformatf("rand%0d t=%0d op=%h", i, type_inst, opcode), m[31:0], m[32]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
